// File: rtl/sf_camera_capture_ctrl_pkg.sv
// Shared definitions for the SF camera capture controller.
// Holds the sequencer state encoding, the datapath widths and a helper that
// maps the requested frame count onto the number of frames actually captured.
package sf_camera_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int SIZE_W  = 24;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_CAM,
    ST_WAIT_LOCK,
    ST_ARM,
    ST_CAPTURE,
    ST_FLUSH
  } state_t;

  // A requested count of zero still captures one frame.
  function automatic logic [FRAME_W-1:0] frame_target(input logic [FRAME_W-1:0] cnt);
    return (cnt == '0) ? FRAME_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/sf_camera_capture_ctrl_if.sv
// Read-FIFO handshake and downstream word stream of the capture controller.
//   rfifo_ready/size/data : camera core read FIFO -> controller
//   rfifo_activate/strobe : controller -> camera core read FIFO
//   data/data_valid       : controller -> downstream consumer
//   data_ready            : downstream consumer -> controller
// master = controller side, slave = camera FIFO + consumer side.
interface sf_camera_capture_ctrl_if;
  import sf_camera_ctrl_pkg::*;

  logic              rfifo_ready;
  logic              rfifo_activate;
  logic              rfifo_strobe;
  logic [DATA_W-1:0] rfifo_data;
  logic [SIZE_W-1:0] rfifo_size;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;

  modport master (
    input  rfifo_ready, rfifo_data, rfifo_size, data_ready,
    output rfifo_activate, rfifo_strobe, data, data_valid
  );

  modport slave (
    output rfifo_ready, rfifo_data, rfifo_size, data_ready,
    input  rfifo_activate, rfifo_strobe, data, data_valid
  );

endinterface

// File: rtl/sf_camera_rfifo_drain.sv
// Drains camera read-FIFO blocks into a registered downstream word stream.
//   clk, rst   : clock, synchronous active-high reset
//   enable_i   : drain may start blocks and pop words
//   flush_i    : drop the active block and the held output word
//   idle_o     : no block active and no word held
//   bus        : read-FIFO handshake + downstream stream (master side)
// The read FIFO is first-word-fall-through: rfifo_data is the word popped by
// a strobe, captured at the same clock edge.
module sf_camera_rfifo_drain
  import sf_camera_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     flush_i,
  output logic                     idle_o,
  sf_camera_capture_ctrl_if.master bus
);

  logic              active_q;
  logic [SIZE_W-1:0] remain_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              pop_c;

  // Pop whenever the output register is free or being emptied this cycle.
  assign pop_c = enable_i && !flush_i && active_q && (remain_q != '0) &&
                 (!valid_q || bus.data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      active_q <= 1'b0;
      remain_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      // The cycle in which active_q reads low after a release is the
      // mandatory gap before the next activate.
      if (!active_q) begin
        if (enable_i && bus.rfifo_ready) begin
          active_q <= 1'b1;
          remain_q <= bus.rfifo_size;
        end
      end else if ((remain_q == '0) || (pop_c && (remain_q == SIZE_W'(1)))) begin
        active_q <= 1'b0;
      end

      if (pop_c) begin
        remain_q <= remain_q - SIZE_W'(1);
        data_q   <= bus.rfifo_data;
        valid_q  <= 1'b1;
      end else if (valid_q && bus.data_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign bus.rfifo_activate = active_q;
  assign bus.rfifo_strobe   = pop_c;
  assign bus.data           = data_q;
  assign bus.data_valid     = valid_q;
  assign idle_o             = !active_q && !valid_q;

endmodule

// File: rtl/sf_camera_capture_ctrl.sv
// SF camera capture sequencer: camera reset, clock-lock wait, count clear,
// frame capture and read-FIFO drain for one multi-frame job per start.
//   clk, rst                    : clock, synchronous active-high reset
//   i_start/i_abort             : job start / job abort pulses
//   i_frame_count, i_flash_en   : job configuration
//   o_busy/o_done/o_error       : job status
//   o_frames_captured           : frames finished in current/last job
//   o_camera_reset, o_reset_counts, o_enable, o_manual_flash_on : camera core controls
//   i_clk_locked, i_captured    : camera core status
//   fifo_if                     : read FIFO handshake + downstream stream
// Optional: define SF_CAMERA_CTRL_TIMEOUT_EN to abort a frame that takes
// TIMEOUT_CYCLES cycles in CAPTURE.
//
// state      | meaning
// IDLE       | no job; waiting for i_start
// RESET_CAM  | camera reset held for RESET_CYCLES cycles
// WAIT_LOCK  | waiting for camera clock lock
// ARM        | one-cycle frame counter clear
// CAPTURE    | capture enabled; waiting for frame-done edge
// FLUSH      | capture off; waiting for drain and FIFO to empty
module sf_camera_capture_ctrl
  import sf_camera_ctrl_pkg::*;
#(
`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000,
`endif
  parameter int RESET_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [FRAME_W-1:0]       i_frame_count,
  input  logic                     i_flash_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [FRAME_W-1:0]       o_frames_captured,
  output logic                     o_camera_reset,
  output logic                     o_reset_counts,
  output logic                     o_enable,
  output logic                     o_manual_flash_on,
  input  logic                     i_clk_locked,
  input  logic                     i_captured,
  sf_camera_capture_ctrl_if.master fifo_if
);

  localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t               state_q;
  logic [RST_CNT_W-1:0] rst_cnt_q;
  logic [FRAME_W-1:0]   target_q;
  logic [FRAME_W-1:0]   frames_q;
  logic                 cap_prev_q;
  logic                 busy_q, done_q, error_q;
  logic                 cam_reset_q, reset_counts_q, enable_q, flash_q;
  logic [FRAME_W-1:0]   frames_inc;
  logic                 cap_rise, abort_c, tmo_hit, drain_idle;

  assign cap_rise   = i_captured && !cap_prev_q;
  assign frames_inc = (frames_q == '1) ? frames_q : frames_q + FRAME_W'(1);
  // Losing clock lock mid-capture is handled exactly like an abort.
  assign abort_c    = i_abort || ((state_q == ST_CAPTURE) && !i_clk_locked) || tmo_hit;

`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
  logic [31:0] tmo_q;

  assign tmo_hit = (state_q == ST_CAPTURE) && (tmo_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_ARM)) tmo_q <= '0;
    else if (state_q == ST_CAPTURE) tmo_q <= tmo_q + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rst_cnt_q      <= '0;
      target_q       <= '0;
      frames_q       <= '0;
      cap_prev_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      cam_reset_q    <= 1'b0;
      reset_counts_q <= 1'b0;
      enable_q       <= 1'b0;
      flash_q        <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      cap_prev_q <= i_captured;
      if (abort_c) begin
        state_q        <= ST_IDLE;
        busy_q         <= 1'b0;
        error_q        <= 1'b1;
        cam_reset_q    <= 1'b0;
        reset_counts_q <= 1'b0;
        enable_q       <= 1'b0;
        flash_q        <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (i_start) begin
            state_q     <= ST_RESET_CAM;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            frames_q    <= '0;
            target_q    <= frame_target(i_frame_count);
            cam_reset_q <= 1'b1;
            rst_cnt_q   <= RST_CNT_W'(RESET_CYCLES - 1);
          end
          ST_RESET_CAM: begin
            if (rst_cnt_q == '0) begin
              cam_reset_q <= 1'b0;
              state_q     <= ST_WAIT_LOCK;
            end else begin
              rst_cnt_q <= rst_cnt_q - RST_CNT_W'(1);
            end
          end
          ST_WAIT_LOCK: if (i_clk_locked) begin
            reset_counts_q <= 1'b1;
            state_q        <= ST_ARM;
          end
          ST_ARM: begin
            reset_counts_q <= 1'b0;
            enable_q       <= 1'b1;
            flash_q        <= i_flash_en;
            state_q        <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            flash_q <= i_flash_en;
            if (cap_rise) begin
              frames_q <= frames_inc;
              enable_q <= 1'b0;
              flash_q  <= 1'b0;
              if (frames_inc == target_q) begin
                state_q <= ST_FLUSH;
              end else begin
                reset_counts_q <= 1'b1;
                state_q        <= ST_ARM;
              end
            end
          end
          ST_FLUSH: if (drain_idle && !fifo_if.rfifo_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sf_camera_rfifo_drain u_drain (
    .clk      (clk),
    .rst      (rst),
    .enable_i (busy_q),
    .flush_i  (abort_c),
    .idle_o   (drain_idle),
    .bus      (fifo_if)
  );

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_error           = error_q;
  assign o_frames_captured = frames_q;
  assign o_camera_reset    = cam_reset_q;
  assign o_reset_counts    = reset_counts_q;
  assign o_enable          = enable_q;
  assign o_manual_flash_on = flash_q;

endmodule
